// File: rtl/decode_group_latch_pkg.sv
// decode_group_latch_pkg: shared slot record, widths and thermometer helper for the decode latch
package decode_group_latch_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int RAS_W = 3;
    localparam int SLOTS = 3;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] inst;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        logic                  bp;
        logic [DATA_WIDTH-1:0] pcpred;
        logic [RAS_W-1:0]      ras;
    } fetch_slot_t;
    function automatic logic [SLOTS-1:0] thermo3(input logic [1:0] n);
        return n == 2'd0 ? 3'b000 : n == 2'd1 ? 3'b001 : n == 2'd2 ? 3'b011 : 3'b111;
    endfunction
endpackage

// File: rtl/decode_group_latch_if.sv
// decode_group_latch_if: buffer-side handshake plus rename-side held-group view
interface decode_group_latch_if;
    import decode_group_latch_pkg::*;
    logic                                flush_i;
    logic [SLOTS-1:0]                    decode_valid_i;
    logic [SLOTS-1:0]                    decode_ready_o;
    logic [SLOTS-1:0][DATA_WIDTH-1:0]    instruction_i;
    logic [SLOTS-1:0][DATA_WIDTH-1:0]    pc_i;
    logic [SLOTS-1:0][DATA_WIDTH-1:0]    imm_i;
    logic [SLOTS-1:0]                    branch_prediction_i;
    logic [SLOTS-1:0][DATA_WIDTH-1:0]    pc_value_at_prediction_i;
    logic [RAS_W-1:0]                    ras_tos_checkpoint_i;
    logic [SLOTS-1:0]                    slot_valid_o;
    fetch_slot_t [SLOTS-1:0]             slot_o;
    logic [1:0]                          accept_count_i;
    logic [1:0]                          occupancy_o;
    modport master (
        output flush_i, decode_valid_i, instruction_i, pc_i, imm_i, branch_prediction_i,
               pc_value_at_prediction_i, ras_tos_checkpoint_i, accept_count_i,
        input  decode_ready_o, slot_valid_o, slot_o, occupancy_o
    );
    modport slave (
        input  flush_i, decode_valid_i, instruction_i, pc_i, imm_i, branch_prediction_i,
               pc_value_at_prediction_i, ras_tos_checkpoint_i, accept_count_i,
        output decode_ready_o, slot_valid_o, slot_o, occupancy_o
    );
endinterface

// File: rtl/decode_group_latch_compactor.sv
// decode_group_latch_compactor: shifts survivors to slot 0 and appends newly taken entries behind them
module decode_group_latch_compactor
    import decode_group_latch_pkg::*;
(
    input  fetch_slot_t [SLOTS-1:0] i_old,
    input  logic [1:0]              i_cnt,
    input  logic [1:0]              i_acc,
    input  fetch_slot_t [SLOTS-1:0] i_new,
    input  logic [1:0]              i_take,
    output fetch_slot_t [SLOTS-1:0] o_next
);
    logic [1:0] w_surv;
    assign w_surv = i_cnt - i_acc;
    // vacated slots keep stale data; validity comes from the count alone
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            o_next[i] = i_old[i];
            if (2'(i) < w_surv)
                o_next[i] = i_old[2'(i) + i_acc];
            else if (2'(i) - w_surv < i_take)
                o_next[i] = i_new[2'(i) - w_surv];
        end
    end
endmodule

// File: rtl/decode_group_latch.sv
// decode_group_latch: 3-entry in-order latch between instruction buffer pop and decode/rename
module decode_group_latch
    import decode_group_latch_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    decode_group_latch_if.slave bus
);
    logic [1:0]              r_cnt;
    fetch_slot_t [SLOTS-1:0] r_slot;
    fetch_slot_t [SLOTS-1:0] w_new;
    fetch_slot_t [SLOTS-1:0] w_next;
    logic [1:0]              w_acc;
    logic [1:0]              w_free;
    logic [1:0]              w_take;
    logic [SLOTS-1:0]        w_hit;
    assign w_acc  = bus.flush_i ? 2'd0 : (bus.accept_count_i > r_cnt ? r_cnt : bus.accept_count_i);
    assign w_free = 2'd3 - r_cnt + w_acc;
    assign bus.decode_ready_o = (reset || bus.flush_i) ? 3'b000 : thermo3(w_free);
    assign w_hit  = bus.decode_valid_i & bus.decode_ready_o;
    // only the contiguous low run of valid&ready is popped
    assign w_take = !w_hit[0] ? 2'd0 : !w_hit[1] ? 2'd1 : !w_hit[2] ? 2'd2 : 2'd3;
    always_comb begin
        for (int i = 0; i < SLOTS; i++)
            w_new[i] = '{inst: bus.instruction_i[i], pc: bus.pc_i[i], imm: bus.imm_i[i],
                         bp: bus.branch_prediction_i[i], pcpred: bus.pc_value_at_prediction_i[i],
                         ras: bus.ras_tos_checkpoint_i};
    end
    decode_group_latch_compactor u_compactor (
        .i_old  (r_slot),
        .i_cnt  (r_cnt),
        .i_acc  (w_acc),
        .i_new  (w_new),
        .i_take (w_take),
        .o_next (w_next)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= 2'd0;
            r_slot <= '0;
        end else if (bus.flush_i) begin
            r_cnt  <= 2'd0;
        end else begin
            r_cnt  <= r_cnt - w_acc + w_take;
            r_slot <= w_next;
        end
    end
    assign bus.slot_valid_o = thermo3(r_cnt);
    assign bus.occupancy_o  = r_cnt;
    assign bus.slot_o       = r_slot;
endmodule
